// File: rtl/player_move_ctrl.sv
// Grid movement controller for the chicken: turns button edges into moves,
// queries the obstacle blocks for the target cell, and tracks death and score.
module player_move_ctrl #(
  parameter int         GRID_WIDTH  = 16,
  parameter int         GRID_HEIGHT = 12,
  parameter logic [3:0] START_X     = 4'd7,
  parameter logic [3:0] START_Y     = 4'd11,
  parameter int         COOLDOWN    = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       restart,
  output logic [3:0] blocked_x,
  output logic [3:0] blocked_y,
  input  logic       is_obstacle,
  input  logic       is_moving_obstacle,
  output logic [3:0] player_x,
  output logic [3:0] player_y,
  output logic       move_ack,
  output logic       move_rej,
  output logic       dead,
  output logic [7:0] score,
  output logic [1:0] state_dbg
);

  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUERY    = 2'd1,
    COOLDOWN_ST = 2'd2,
    DEAD     = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [3:0]    px_q, py_q, px_n, py_n;
  logic [3:0]    cx_q, cy_q, cx_n, cy_n;
  logic [3:0]    min_row_q, min_row_n;
  logic [7:0]    score_q, score_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          ack_n, rej_n;
  logic [4:0]    hist_q;
  logic [4:0]    edges;
  logic [4:0]    cand_x5, cand_y5;
  logic          any_press, oob;

  // Bit order: {restart, right, left, down, up}
  assign edges = {restart, btn_right, btn_left, btn_down, btn_up} & ~hist_q;

  always_comb begin
    cand_x5   = {1'b0, px_q};
    cand_y5   = {1'b0, py_q};
    any_press = 1'b1;
    if (edges[0])      cand_y5 = {1'b0, py_q} - 5'd1;
    else if (edges[1]) cand_y5 = {1'b0, py_q} + 5'd1;
    else if (edges[2]) cand_x5 = {1'b0, px_q} - 5'd1;
    else if (edges[3]) cand_x5 = {1'b0, px_q} + 5'd1;
    else               any_press = 1'b0;
    // Underflow wraps to 31 in 5 bits, so one upper-bound test covers both edges.
    oob = (cand_x5 >= 5'(GRID_WIDTH)) || (cand_y5 >= 5'(GRID_HEIGHT));
  end

  always_comb begin
    state_n   = state_q;
    px_n      = px_q;
    py_n      = py_q;
    cx_n      = cx_q;
    cy_n      = cy_q;
    min_row_n = min_row_q;
    score_n   = score_q;
    cnt_n     = cnt_q;
    ack_n     = 1'b0;
    rej_n     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_moving_obstacle) begin
          state_n = DEAD;
        end else if (any_press) begin
          if (oob) begin
            rej_n = 1'b1;
          end else begin
            cx_n    = cand_x5[3:0];
            cy_n    = cand_y5[3:0];
            state_n = QUERY;
          end
        end
      end
      QUERY: begin
        if (is_moving_obstacle) begin
          px_n    = cx_q;
          py_n    = cy_q;
          state_n = DEAD;
        end else if (is_obstacle) begin
          rej_n   = 1'b1;
          state_n = IDLE;
        end else begin
          px_n    = cx_q;
          py_n    = cy_q;
          ack_n   = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = COOLDOWN_ST;
          if (cy_q < min_row_q) begin
            min_row_n = cy_q;
            if (score_q != 8'hFF) score_n = score_q + 8'd1;
          end
        end
      end
      COOLDOWN_ST: begin
        if (is_moving_obstacle)  state_n = DEAD;
        else if (cnt_q == '0)    state_n = IDLE;
        else                     cnt_n   = cnt_q - 1'b1;
      end
      DEAD: begin
        if (edges[4]) begin
          px_n      = START_X;
          py_n      = START_Y;
          score_n   = 8'd0;
          min_row_n = START_Y;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      px_q      <= START_X;
      py_q      <= START_Y;
      cx_q      <= START_X;
      cy_q      <= START_Y;
      min_row_q <= START_Y;
      score_q   <= 8'd0;
      cnt_q     <= '0;
      move_ack  <= 1'b0;
      move_rej  <= 1'b0;
      hist_q    <= 5'd0;
    end else begin
      state_q   <= state_n;
      px_q      <= px_n;
      py_q      <= py_n;
      cx_q      <= cx_n;
      cy_q      <= cy_n;
      min_row_q <= min_row_n;
      score_q   <= score_n;
      cnt_q     <= cnt_n;
      move_ack  <= ack_n;
      move_rej  <= rej_n;
      hist_q    <= {restart, btn_right, btn_left, btn_down, btn_up};
    end
  end

  assign blocked_x = (state_q == QUERY) ? cx_q : px_q;
  assign blocked_y = (state_q == QUERY) ? cy_q : py_q;
  assign player_x  = px_q;
  assign player_y  = py_q;
  assign score     = score_q;
  assign dead      = (state_q == DEAD);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: bounds, obstacles, cooldown, death,
// restart, priority and mid-query reset, with COOLDOWN shortened to 4.
module tb_player_move_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_QUERY = 2'd1, S_COOL = 2'd2, S_DEAD = 2'd3;
  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] blocked_x, blocked_y, player_x, player_y;
  logic       is_obstacle, is_moving_obstacle;
  logic       move_ack, move_rej, dead;
  logic [7:0] score;
  logic [1:0] state_dbg;

  // Obstacle environment: one static and one moving obstacle cell.
  logic       obs_en = 1'b0, mov_en = 1'b0;
  logic [3:0] obs_x = 4'd0, obs_y = 4'd0, mov_x = 4'd0, mov_y = 4'd0;
  assign is_obstacle        = obs_en && (blocked_x == obs_x) && (blocked_y == obs_y);
  assign is_moving_obstacle = mov_en && (blocked_x == mov_x) && (blocked_y == mov_y);

  int n_checks = 0;
  int n_fail   = 0;
  int exp_x = 7, exp_y = 11, exp_min = 11, exp_score = 0;

  player_move_ctrl #(.COOLDOWN(4)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .restart(restart),
    .blocked_x(blocked_x), .blocked_y(blocked_y),
    .is_obstacle(is_obstacle), .is_moving_obstacle(is_moving_obstacle),
    .player_x(player_x), .player_y(player_y),
    .move_ack(move_ack), .move_rej(move_rej), .dead(dead), .score(score),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int dir, input logic v);
    case (dir)
      UP:      btn_up    = v;
      DOWN:    btn_down  = v;
      LEFT:    btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, player_x, x);
    check({tag, "_y"}, player_y, y);
  endtask

  // Legal move with no obstacle at the target; caller is at a negedge in IDLE.
  task automatic move_ok(input int dir);
    int nx, ny;
    nx = exp_x; ny = exp_y;
    case (dir)
      UP:      ny = ny - 1;
      DOWN:    ny = ny + 1;
      LEFT:    nx = nx - 1;
      default: nx = nx + 1;
    endcase
    set_btn(dir, 1'b1);
    @(negedge clk);
    set_btn(dir, 1'b0);
    check("query_state", state_dbg, S_QUERY);
    check("query_x", blocked_x, nx);
    check("query_y", blocked_y, ny);
    @(negedge clk);
    check("ack", move_ack, 1);
    check("rej_with_ack", move_rej, 0);
    exp_x = nx; exp_y = ny;
    if (ny < exp_min) begin
      exp_min = ny;
      if (exp_score < 255) exp_score++;
    end
    check_pos("move", exp_x, exp_y);
    check("score", score, exp_score);
    @(negedge clk);
    check("ack_one_cycle", move_ack, 0);
    repeat (4) @(negedge clk);
    check("back_idle", state_dbg, S_IDLE);
  endtask

  // Out-of-bounds press: rejected from IDLE without a query cycle.
  task automatic press_rej(input int dir);
    set_btn(dir, 1'b1);
    @(negedge clk);
    set_btn(dir, 1'b0);
    check("oob_rej", move_rej, 1);
    check("oob_state", state_dbg, S_IDLE);
    @(negedge clk);
    check("oob_rej_one_cycle", move_rej, 0);
    check_pos("oob_pos", exp_x, exp_y);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_state", state_dbg, S_IDLE);
    check_pos("rst_pos", 7, 11);
    check("rst_score", score, 0);
    check("rst_ack", move_ack, 0);
    check("rst_rej", move_rej, 0);
    check("rst_dead", dead, 0);
    rst = 1'b1;
    @(negedge clk);

    // First move up: (7,11) -> (7,10), score 1.
    move_ok(UP);

    // Second press 2 cycles after the first lands in cooldown and is dropped.
    btn_up = 1'b1;
    @(negedge clk); btn_up = 1'b0;
    @(negedge clk);
    check("cd_first_ack", move_ack, 1);
    check_pos("cd_first", 7, 9);
    btn_up = 1'b1;
    @(negedge clk); btn_up = 1'b0;
    check("cd_state", state_dbg, S_COOL);
    @(negedge clk);
    check("cd_drop_ack", move_ack, 0);
    check_pos("cd_drop", 7, 9);
    exp_y = 9; exp_min = 9; exp_score = 2;
    check("cd_score", score, 2);
    repeat (3) @(negedge clk);
    move_ok(UP);
    check("after_cd_score", score, 3);

    // Revisiting an already reached row gives no points.
    move_ok(DOWN);
    move_ok(UP);
    check("revisit_score", score, 3);

    // Up and right together: up wins.
    btn_up = 1'b1; btn_right = 1'b1;
    @(negedge clk);
    btn_up = 1'b0; btn_right = 1'b0;
    check("prio_qx", blocked_x, 7);
    check("prio_qy", blocked_y, 7);
    @(negedge clk);
    check("prio_ack", move_ack, 1);
    check_pos("prio", 7, 7);
    exp_y = 7; exp_min = 7; exp_score = 4;
    check("prio_score", score, 4);
    repeat (5) @(negedge clk);

    // Walk to the edges and push against each boundary.
    repeat (2) move_ok(UP);
    repeat (7) move_ok(LEFT);
    check_pos("at_left_edge", 0, 5);
    press_rej(LEFT);
    repeat (15) move_ok(RIGHT);
    press_rej(RIGHT);
    repeat (6) move_ok(DOWN);
    press_rej(DOWN);
    check("edge_score", score, 6);

    // Reset asserted while a query is in flight.
    btn_up = 1'b1;
    @(negedge clk);
    btn_up = 1'b0;
    check("mid_q_state", state_dbg, S_QUERY);
    rst = 1'b0;
    #1;
    check_pos("mid_q_rst", 7, 11);
    check("mid_q_rst_state", state_dbg, S_IDLE);
    check("mid_q_rst_score", score, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_q_no_ack", move_ack, 0);
    check_pos("mid_q_after", 7, 11);
    exp_x = 7; exp_y = 11; exp_min = 11; exp_score = 0;

    // Static obstacle directly above.
    obs_en = 1'b1; obs_x = 4'd7; obs_y = 4'd10;
    btn_up = 1'b1;
    @(negedge clk);
    btn_up = 1'b0;
    check("obs_query", state_dbg, S_QUERY);
    @(negedge clk);
    check("obs_rej", move_rej, 1);
    check("obs_no_ack", move_ack, 0);
    check_pos("obs_pos", 7, 11);
    check("obs_state", state_dbg, S_IDLE);
    check("obs_score", score, 0);
    obs_en = 1'b0;
    @(negedge clk);

    // Moving obstacle on the target cell: player steps onto it and dies.
    mov_en = 1'b1; mov_x = 4'd7; mov_y = 4'd10;
    btn_up = 1'b1;
    @(negedge clk);
    btn_up = 1'b0;
    @(negedge clk);
    check("train_dead", dead, 1);
    check_pos("train_pos", 7, 10);
    check("train_no_ack", move_ack, 0);
    mov_en = 1'b0;
    btn_left = 1'b1;
    @(negedge clk); btn_left = 1'b0;
    @(negedge clk);
    check_pos("dead_frozen", 7, 10);
    check("dead_hold", dead, 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart1_dead", dead, 0);
    check_pos("restart1", 7, 11);
    check("restart1_state", state_dbg, S_IDLE);
    @(negedge clk);

    // Walk to (3,6), ignore a restart in IDLE, then get hit while standing still.
    repeat (5) move_ok(UP);
    repeat (4) move_ok(LEFT);
    check_pos("at_3_6", 3, 6);
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    @(negedge clk);
    check_pos("idle_restart_ignored", 3, 6);
    check("idle_restart_score", score, 5);
    mov_en = 1'b1; mov_x = 4'd3; mov_y = 4'd6;
    @(negedge clk);
    check("hit_dead", dead, 1);
    check_pos("hit_pos", 3, 6);
    mov_en = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart2_dead", dead, 0);
    check_pos("restart2", 7, 11);
    check("restart2_score", score, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
